ex_alu_stage: RTL and testbench

- Registered execute stage sitting directly upstream of the EX/MEM boundary; it consumes decoded operands from ID/EX and produces the 64-bit ALU result, including the arithmetic-right-shift path.
- Computes one of ten RV64I integer ops per accepted instruction.
- Valid/ready handshake on both sides, with a 2-entry output buffer (output register plus skid) so that memory-stage stalls never drop an op.
- Includes a saturating stall-cycle counter for performance debug.

---
 rtl/ex_alu_stage.sv | 125 ++++++++++++
 tb/tb_ex_alu_stage.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_alu_stage.sv
// RV64I execute stage: ten-op ALU feeding a registered output
// with a one-entry skid buffer and a saturating stall counter.
module ex_alu_stage #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_alu_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [4:0]       in_rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic             out_zero,
  output logic [4:0]       out_rd,
  output logic             out_illegal,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic            zero;
    logic [4:0]      rd;
    logic            illegal;
  } res_t;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;

  res_t            out_q;
  res_t            skid_q;
  logic            skid_valid;
  res_t            alu;
  logic [XLEN-1:0] res;
  logic            ill;
  logic [5:0]      sh;
  logic            accept;
  logic            drain;

  assign sh     = in_b[5:0];
  assign accept = in_valid && in_ready;
  assign drain  = out_valid && out_ready;

  // ALU function; unused op codes yield zero and flag illegal
  always_comb begin
    res = '0;
    ill = 1'b0;
    unique case (in_alu_op)
      OP_ADD:  res = in_a + in_b;
      OP_SUB:  res = in_a - in_b;
      OP_AND:  res = in_a & in_b;
      OP_OR:   res = in_a | in_b;
      OP_XOR:  res = in_a ^ in_b;
      OP_SLL:  res = in_a << sh;
      OP_SRL:  res = in_a >> sh;
      OP_SRA:  res = $signed(in_a) >>> sh;
      OP_SLT:  res = {{(XLEN-1){1'b0}},
                      $signed(in_a) < $signed(in_b)};
      OP_SLTU: res = {{(XLEN-1){1'b0}}, in_a < in_b};
      default: ill = 1'b1;
    endcase
  end

  assign alu.result  = res;
  assign alu.zero    = (res == '0);
  assign alu.rd      = in_rd;
  assign alu.illegal = ill;

  // skid_valid is pure state, so in_ready never sees out_ready
  assign in_ready = !skid_valid;

  // output register and skid buffer, filled in acceptance order
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q      <= '{result: '0, zero: 1'b1,
                      rd: '0, illegal: 1'b0};
      skid_q     <= '0;
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (accept) begin
      if (!out_valid || drain) begin
        out_q     <= alu;
        out_valid <= 1'b1;
      end else begin
        skid_q     <= alu;
        skid_valid <= 1'b1;
      end
    end else if (drain) begin
      if (skid_valid) begin
        out_q      <= skid_q;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  // count cycles the memory stage holds off a valid result
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready
                 && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign out_result  = out_q.result;
  assign out_zero    = out_q.zero;
  assign out_rd      = out_q.rd;
  assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_ex_alu_stage.sv
// Bench for ex_alu_stage: directed vectors, backpressure,
// saturation, mid-flight reset and a randomized scoreboard.
module tb_ex_alu_stage;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    in_alu_op = '0;
  logic [63:0]   in_a = '0;
  logic [63:0]   in_b = '0;
  logic [4:0]    in_rd = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [63:0]   out_result;
  logic          out_zero;
  logic [4:0]    out_rd;
  logic          out_illegal;
  logic [CW-1:0] stall_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ex_alu_stage #(.XLEN(64), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_op(in_alu_op), .in_a(in_a), .in_b(in_b),
    .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero),
    .out_rd(out_rd), .out_illegal(out_illegal),
    .stall_cnt(stall_cnt)
  );

  // reference: {illegal, result}
  function automatic logic [64:0] ref_alu(
    input logic [3:0] op, input logic [63:0] a,
    input logic [63:0] b);
    logic [63:0] r;
    int n;
    n = int'(b[5:0]);
    r = '0;
    case (op)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = a << n;
      4'd6: r = a >> n;
      4'd7: begin
        r = a;
        for (int k = 0; k < n; k++) r = {r[63], r[63:1]};
      end
      4'd8: r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      4'd9: r = (a < b) ? 64'd1 : 64'd0;
      default: return {1'b1, 64'd0};
    endcase
    return {1'b0, r};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_hs got v=%b r=%b want 0 1",
               out_valid, in_ready);
    end
    checks++;
    if (out_result !== 64'd0 || out_zero !== 1'b1) begin
      failures++;
      $display("FAIL reset_res got %h z=%b want 0 z=1",
               out_result, out_zero);
    end
    checks++;
    if (out_rd !== 5'd0 || out_illegal !== 1'b0
        || stall_cnt !== '0) begin
      failures++;
      $display("FAIL reset_misc got rd=%0d il=%b sc=%0d",
               out_rd, out_illegal, stall_cnt);
    end
  endtask

  task automatic test_vectors();
    logic [3:0]  op[9] = '{4'd7, 4'd7, 4'd7, 4'd7, 4'd1,
                           4'd8, 4'd9, 4'd12, 4'd5};
    logic [63:0] va[9] = '{64'h8000_0000_0000_0000,
                           64'h7FFF_FFFF_FFFF_FFFF,
                           64'hFFFF_FFFF_FFFF_FF00,
                           64'h8000_0000_0000_0001,
                           64'd5, '1, '1, 64'd77, 64'd1};
    logic [63:0] vb[9] = '{64'd4, 64'h47, 64'd63, 64'h40,
                           64'd5, 64'd1, 64'd1, 64'd3,
                           64'h41};
    logic [63:0] ex[9] = '{64'hF800_0000_0000_0000,
                           64'h00FF_FFFF_FFFF_FFFF, '1,
                           64'h8000_0000_0000_0001,
                           64'd0, 64'd1, 64'd0, 64'd0,
                           64'd2};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1;
      in_alu_op = op[i];
      in_a = va[i];
      in_b = vb[i];
      in_rd = 5'(i + 3);
      out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_result !== ex[i]) begin
        failures++;
        $display("FAIL vec%0d got v=%b %h want 1 %h",
                 i, out_valid, out_result, ex[i]);
      end
      checks++;
      if (out_zero !== (ex[i] == 0)
          || out_illegal !== (op[i] > 9)
          || out_rd !== 5'(i + 3)) begin
        failures++;
        $display("FAIL vec%0d_flags got z=%b il=%b rd=%0d",
                 i, out_zero, out_illegal, out_rd);
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [63:0] got[$];
    logic acc;
    do_reset();
    in_valid = 1'b1;
    in_alu_op = 4'd0;
    in_a = 64'd0;
    in_b = 64'd1;
    @(negedge clk);
    out_ready = 1'b0;
    in_a = 64'd1;
    in_b = 64'd1;
    @(negedge clk);
    in_a = 64'd1;
    in_b = 64'd2;
    checks++;
    if (out_valid !== 1'b1 || out_result !== 64'd1
        || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_full got v=%b %0d rdy=%b want 1 1 0",
               out_valid, out_result, in_ready);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (stall_cnt !== 4'd4) begin
      failures++;
      $display("FAIL bp_stall got %0d want 4", stall_cnt);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) got.push_back(out_result);
      acc = in_valid && in_ready;
      @(negedge clk);
      if (acc) in_valid = 1'b0;
    end
    checks++;
    if (got.size() != 3) begin
      failures++;
      $display("FAIL bp_count got %0d want 3", got.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got[i] !== 64'(i + 1)) begin
          failures++;
          $display("FAIL bp_order%0d got %0d want %0d",
                   i, got[i], i + 1);
        end
      end
    end
    checks++;
    if (stall_cnt !== 4'd4) begin
      failures++;
      $display("FAIL bp_stall_hold got %0d want 4", stall_cnt);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    in_valid = 1'b1;
    in_alu_op = 4'd0;
    in_a = 64'd9;
    in_b = 64'd0;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (stall_cnt !== 4'd10) begin
      failures++;
      $display("FAIL sat_mid got %0d want 10", stall_cnt);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (stall_cnt !== 4'hF) begin
      failures++;
      $display("FAIL sat_top got %0d want 15", stall_cnt);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (stall_cnt !== 4'hF || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL sat_hold got %0d v=%b want 15 0",
               stall_cnt, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    bit stale;
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_alu_op = 4'd3;
    in_a = 64'hA5;
    in_b = 64'h5A00;
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL mid_full got rdy=%b v=%b want 0 1",
               in_ready, out_valid);
    end
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1
        || stall_cnt !== '0) begin
      failures++;
      $display("FAIL mid_reset got v=%b r=%b sc=%0d",
               out_valid, in_ready, stall_cnt);
    end
    out_ready = 1'b1;
    stale = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stale = 1'b1;
    end
    checks++;
    if (stale) begin
      failures++;
      $display("FAIL mid_stale got stale=1 want 0");
    end
  endtask

  task automatic test_random();
    logic [69:0] q[$];
    logic [69:0] e;
    logic [64:0] r;
    int sc;
    do_reset();
    sc = 0;
    for (int c = 0; c < 400; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_alu_op = 4'($urandom_range(0, 15));
      in_a = {$urandom, $urandom};
      in_b = ($urandom_range(0, 5) == 0) ? in_a
             : {$urandom, $urandom};
      in_rd = 5'($urandom_range(0, 31));
      #1;
      checks++;
      if (out_valid !== (q.size() > 0)
          || in_ready !== (q.size() < 2)) begin
        failures++;
        $display("FAIL rnd_occ c=%0d got v=%b r=%b n=%0d",
                 c, out_valid, in_ready, q.size());
      end
      checks++;
      if (stall_cnt !== CW'(sc)) begin
        failures++;
        $display("FAIL rnd_stall c=%0d got %0d want %0d",
                 c, stall_cnt, sc);
      end
      if (q.size() > 0 && !out_ready && sc < 15) sc++;
      if (out_valid && out_ready && q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (out_result !== e[69:6] || out_illegal !== e[0]
            || out_rd !== e[5:1]
            || out_zero !== (e[69:6] == 0)) begin
          failures++;
          $display("FAIL rnd_data c=%0d got %h want %h",
                   c, out_result, e[69:6]);
        end
      end
      if (in_valid && in_ready) begin
        r = ref_alu(in_alu_op, in_a, in_b);
        q.push_back({r[63:0], in_rd, r[64]});
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
